// File: rtl/imm_ext_ctrl_if.sv
// Handshake bundle for imm_ext_ctrl: instruction in, extended immediate out,
// plus flush and the debug delivery counter.
interface imm_ext_ctrl_if;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] imm_o;
  logic [2:0]  mode_o;
  logic [15:0] cnt_o;

  modport slave (
    input  flush_i, in_valid_i, instr_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, mode_o, cnt_o
  );

  modport master (
    output flush_i, in_valid_i, instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, mode_o, cnt_o
  );
endinterface

// File: rtl/imm_ext_ctrl.sv
// Registered immediate-extension controller with a two-entry skid buffer.
// Optional macro IMM_BRANCH_SHIFT_EN turns branch immediates into byte offsets.
module imm_ext_ctrl (
  input  logic            clk_i,
  input  logic            rst_i,
  imm_ext_ctrl_if.slave   bus
);

  localparam logic [2:0] MODE_NONE   = 3'd0;
  localparam logic [2:0] MODE_SIGN   = 3'd1;
  localparam logic [2:0] MODE_ZERO   = 3'd2;
  localparam logic [2:0] MODE_UPPER  = 3'd3;
  localparam logic [2:0] MODE_BRANCH = 3'd4;

  // Returns {mode, imm} for one instruction word.
  function automatic logic [34:0] decode(input logic [31:0] instr);
    logic [15:0] imm;
    logic [34:0] res;
    imm = instr[15:0];
    case (instr[31:26])
      6'b001000, 6'b001010, 6'b100011, 6'b101011:
        res = {MODE_SIGN, {16{imm[15]}}, imm};
      6'b001100, 6'b001101:
        res = {MODE_ZERO, 16'h0000, imm};
      6'b001111:
        res = {MODE_UPPER, imm, 16'h0000};
      6'b000100, 6'b000101:
`ifdef IMM_BRANCH_SHIFT_EN
        res = {MODE_BRANCH, {14{imm[15]}}, imm, 2'b00};
`else
        res = {MODE_BRANCH, {16{imm[15]}}, imm};
`endif
      default:
        res = {MODE_NONE, 32'h0000_0000};
    endcase
    return res;
  endfunction

  logic        out_valid_r, out_valid_s;
  logic [31:0] out_imm_r,   out_imm_s;
  logic [2:0]  out_mode_r,  out_mode_s;
  logic        skid_valid_r, skid_valid_s;
  logic [31:0] skid_imm_r,  skid_imm_s;
  logic [2:0]  skid_mode_r, skid_mode_s;
  logic        in_ready_r,  in_ready_s;
  logic [15:0] cnt_r,       cnt_s;
  logic [34:0] dec_s;
  logic        accept_s;
  logic        fire_s;

  // Next-state logic for the output/skid pair and the delivery counter.
  always_comb begin
    dec_s        = decode(bus.instr_i);
    accept_s     = bus.in_valid_i && in_ready_r;
    fire_s       = out_valid_r && bus.out_ready_i;
    out_valid_s  = out_valid_r;
    out_imm_s    = out_imm_r;
    out_mode_s   = out_mode_r;
    skid_valid_s = skid_valid_r;
    skid_imm_s   = skid_imm_r;
    skid_mode_s  = skid_mode_r;

    if (bus.flush_i) begin
      out_valid_s  = 1'b0;
      skid_valid_s = 1'b0;
    end else if (!out_valid_r || fire_s) begin
      if (skid_valid_r) begin
        out_valid_s  = 1'b1;
        out_imm_s    = skid_imm_r;
        out_mode_s   = skid_mode_r;
        skid_valid_s = accept_s;
        if (accept_s) begin
          skid_imm_s  = dec_s[31:0];
          skid_mode_s = dec_s[34:32];
        end else begin
          skid_imm_s  = skid_imm_r;
          skid_mode_s = skid_mode_r;
        end
      end else begin
        out_valid_s  = accept_s;
        skid_valid_s = 1'b0;
        if (accept_s) begin
          out_imm_s  = dec_s[31:0];
          out_mode_s = dec_s[34:32];
        end else begin
          out_imm_s  = out_imm_r;
          out_mode_s = out_mode_r;
        end
      end
    end else begin
      // Output is stalled; accept is only possible while the skid is empty.
      if (accept_s) begin
        skid_valid_s = 1'b1;
        skid_imm_s   = dec_s[31:0];
        skid_mode_s  = dec_s[34:32];
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end

    in_ready_s = !skid_valid_s;

    if (!bus.flush_i && fire_s && (cnt_r != 16'hFFFF)) begin
      cnt_s = cnt_r + 16'd1;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_r  <= 1'b0;
      out_imm_r    <= 32'h0000_0000;
      out_mode_r   <= MODE_NONE;
      skid_valid_r <= 1'b0;
      skid_imm_r   <= 32'h0000_0000;
      skid_mode_r  <= MODE_NONE;
      in_ready_r   <= 1'b1;
      cnt_r        <= 16'h0000;
    end else begin
      out_valid_r  <= out_valid_s;
      out_imm_r    <= out_imm_s;
      out_mode_r   <= out_mode_s;
      skid_valid_r <= skid_valid_s;
      skid_imm_r   <= skid_imm_s;
      skid_mode_r  <= skid_mode_s;
      in_ready_r   <= in_ready_s;
      cnt_r        <= cnt_s;
    end
  end

  assign bus.in_ready_o  = in_ready_r;
  assign bus.out_valid_o = out_valid_r;
  assign bus.imm_o       = out_imm_r;
  assign bus.mode_o      = out_mode_r;
  assign bus.cnt_o       = cnt_r;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Scoreboard bench for imm_ext_ctrl: stimulus pushes expected immediates,
// a negedge monitor pops and compares on every output handshake.
module tb_imm_ext_ctrl;

  logic clk;
  logic rst;
  imm_ext_ctrl_if bus ();

  imm_ext_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  mode;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'h0000;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'h000, imm};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction until accepted; expectation is queued at acceptance.
  task automatic send(input logic [31:0] ins, input logic [31:0] ei, input logic [2:0] em);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    bus.in_valid_i = 1'b1;
    bus.instr_i    = ins;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        sb.push_back('{imm: ei, mode: em});
        done = 1'b1;
      end
      tick();
      n++;
      if (!done && n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=stalled required=accept");
        done = 1'b1;
      end
    end
    bus.in_valid_i = 1'b0;
  endtask

  // Monitor: compare every output handshake against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 16'h0000;
    end else if (bus.out_valid_o && bus.out_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=0x%08h required=none", bus.imm_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.imm_o !== e.imm || bus.mode_o !== e.mode) begin
          errors++;
          $display("FAIL output actual=0x%08h/%0d required=0x%08h/%0d",
                   bus.imm_o, bus.mode_o, e.imm, e.mode);
        end
      end
      if (!bus.flush_i && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] beq_exp;
  logic [15:0] cnt_saved;

  initial begin
`ifdef IMM_BRANCH_SHIFT_EN
    beq_exp = 32'hFFFF_FFFC;
`else
    beq_exp = 32'hFFFF_FFFF;
`endif
    rst = 1'b1;
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.instr_i     = 32'h0000_0000;
    bus.out_ready_i = 1'b0;
    #2;
    check32("reset_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check32("reset_imm", bus.imm_o, 32'h0000_0000);
    check32("reset_mode", {29'd0, bus.mode_o}, 32'd0);
    check32("reset_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    check32("reset_cnt", {16'd0, bus.cnt_o}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Back-pressure: two accepted, third waits for the skid to drain.
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.instr_i     = mk(6'b001000, 16'h0001);
    @(negedge clk);
    check32("bp_ready0", {31'd0, bus.in_ready_o}, 32'd1);
    sb.push_back('{imm: 32'h1, mode: 3'd1});
    tick();
    bus.instr_i = mk(6'b001000, 16'h0002);
    @(negedge clk);
    check32("bp_ready1", {31'd0, bus.in_ready_o}, 32'd1);
    sb.push_back('{imm: 32'h2, mode: 3'd1});
    tick();
    bus.instr_i = mk(6'b001000, 16'h0003);
    @(negedge clk);
    check32("bp_ready_drop", {31'd0, bus.in_ready_o}, 32'd0);
    check32("bp_hold_imm", bus.imm_o, 32'h1);
    tick();
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    check32("bp_still_full", {31'd0, bus.in_ready_o}, 32'd0);
    check32("bp_fire1_valid", {31'd0, bus.out_valid_o}, 32'd1);
    tick();
    @(negedge clk);
    check32("bp_ready_back", {31'd0, bus.in_ready_o}, 32'd1);
    check32("bp_fire2_valid", {31'd0, bus.out_valid_o}, 32'd1);
    sb.push_back('{imm: 32'h3, mode: 3'd1});
    tick();
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check32("bp_fire3_valid", {31'd0, bus.out_valid_o}, 32'd1);
    tick();
    check32("bp_cnt", {16'd0, bus.cnt_o}, 32'd3);
    check32("bp_sb_empty", sb.size(), 32'd0);

    // Flush with both entries buffered.
    bus.out_ready_i = 1'b0;
    cnt_saved = bus.cnt_o;
    send(mk(6'b001000, 16'h0007), 32'h7, 3'd1);
    send(mk(6'b001000, 16'h0008), 32'h8, 3'd1);
    bus.flush_i = 1'b1;
    sb.delete();
    tick();
    bus.flush_i = 1'b0;
    @(negedge clk);
    check32("flush_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check32("flush_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    check32("flush_cnt", {16'd0, bus.cnt_o}, {16'd0, cnt_saved});
    tick();
    bus.out_ready_i = 1'b1;
    send(mk(6'b001111, 16'hABCD), 32'hABCD_0000, 3'd3);
    @(negedge clk);
    check32("flush_lui_valid", {31'd0, bus.out_valid_o}, 32'd1);
    check32("flush_lui_imm", bus.imm_o, 32'hABCD_0000);
    tick();

    // Build cnt = 5 with one entry stalled on the output, then reset async.
    send(mk(6'b001000, 16'h0010), 32'h10, 3'd1);
    tick();
    bus.out_ready_i = 1'b0;
    send(mk(6'b001000, 16'h0011), 32'h11, 3'd1);
    tick();
    check32("pre_rst_cnt", {16'd0, bus.cnt_o}, 32'd5);
    check32("pre_rst_valid", {31'd0, bus.out_valid_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check32("arst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check32("arst_imm", bus.imm_o, 32'h0000_0000);
    check32("arst_mode", {29'd0, bus.mode_o}, 32'd0);
    check32("arst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    check32("arst_cnt", {16'd0, bus.cnt_o}, 32'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();

    // Decode sweep at full throughput.
    bus.out_ready_i = 1'b1;
    send(mk(6'b001000, 16'hFFFC), 32'hFFFF_FFFC, 3'd1);
    send(mk(6'b001101, 16'h8001), 32'h0000_8001, 3'd2);
    send(mk(6'b001111, 16'h1234), 32'h1234_0000, 3'd3);
    send(32'h0022_1820,           32'h0000_0000, 3'd0);
    send(mk(6'b000100, 16'hFFFF), beq_exp,       3'd4);
    send(mk(6'b101011, 16'h8000), 32'hFFFF_8000, 3'd1);
    send(mk(6'b001100, 16'hFFFF), 32'h0000_FFFF, 3'd2);
    tick();
    tick();
    check32("sweep_cnt", {16'd0, bus.cnt_o}, 32'd7);

    // Counter saturation.
    bus.in_valid_i = 1'b1;
    bus.instr_i    = mk(6'b001101, 16'h0001);
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      if (bus.in_ready_o) sb.push_back('{imm: 32'h1, mode: 3'd2});
      tick();
    end
    bus.in_valid_i = 1'b0;
    tick();
    tick();
    check32("sat_cnt", {16'd0, bus.cnt_o}, 32'h0000_FFFF);
    check32("sat_cnt_model", {16'd0, bus.cnt_o}, {16'd0, exp_cnt});
    check32("final_sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
